// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb_pkg
// Description : Shared ALU opcode constants and arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    localparam logic [3:0] c_ALUC_ADD = 4'b0000;
    localparam logic [3:0] c_ALUC_SUB = 4'b0100;
    localparam logic [3:0] c_ALUC_AND = 4'b0001;
    localparam logic [3:0] c_ALUC_OR  = 4'b0101;
    localparam logic [3:0] c_ALUC_XOR = 4'b0010;
    localparam logic [3:0] c_ALUC_LUI = 4'b0110;
    localparam logic [3:0] c_ALUC_SLL = 4'b0011;
    localparam logic [3:0] c_ALUC_SRL = 4'b0111;
    localparam logic [3:0] c_ALUC_SRA = 4'b1111;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    typedef enum logic [0:0] {
        IDLE = c_ST_IDLE,
        HOLD = c_ST_HOLD
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Requester, ALU and response bundle for the two-way ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [3:0]  req0_aluc;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  req1_aluc;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_aluc;
    logic [31:0] alu_s;
    logic        alu_z;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_s;
    logic        rsp_z;

    modport master (
        output req0_valid, req0_a, req0_b, req0_aluc,
        output req1_valid, req1_a, req1_b, req1_aluc,
        output alu_s, alu_z, rsp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_aluc,
        input  rsp_valid, rsp_id, rsp_s, rsp_z
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_aluc,
        input  req1_valid, req1_a, req1_b, req1_aluc,
        input  alu_s, alu_z, rsp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_aluc,
        output rsp_valid, rsp_id, rsp_s, rsp_z
    );
endinterface
`default_nettype wire

// File: rtl/alu_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_arb
// Description : Two-way round-robin grant, one-hot output, purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_arb (
    input  logic [1:0] valids,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant = 2'b00;
        case (valids)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational ALU between two requesters with a
//               one-deep registered response. Optional grant statistics are
//               enabled by defining ALU_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic         clock,
    input  logic         reset,
    alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    state_t      r_state;
    logic        r_last_grant;
    logic        r_rsp_id;
    logic        r_rsp_z;
    logic [31:0] r_rsp_s;
    logic [1:0]  w_grant;
    logic        w_slot_free;
    logic        w_accept;

    alu_rr_arb u_rr_arb (
        .valids     ({bus.req1_valid, bus.req0_valid}),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    // Grant never depends on rsp_ready; only the ready qualification does.
    assign w_slot_free    = ~reset & ((r_state == IDLE) | bus.rsp_ready);
    assign bus.req0_ready = w_grant[0] & w_slot_free;
    assign bus.req1_ready = w_grant[1] & w_slot_free;
    assign w_accept       = (|w_grant) & w_slot_free;

    always_comb begin
        bus.alu_a    = 32'd0;
        bus.alu_b    = 32'd0;
        bus.alu_aluc = 4'b0000;
        if (w_grant[0]) begin
            bus.alu_a    = bus.req0_a;
            bus.alu_b    = bus.req0_b;
            bus.alu_aluc = bus.req0_aluc;
        end else if (w_grant[1]) begin
            bus.alu_a    = bus.req1_a;
            bus.alu_b    = bus.req1_b;
            bus.alu_aluc = bus.req1_aluc;
        end
    end

    assign bus.rsp_valid = (r_state == HOLD);
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_s     = r_rsp_s;
    assign bus.rsp_z     = r_rsp_z;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_rsp_id     <= 1'b0;
            r_rsp_s      <= 32'd0;
            r_rsp_z      <= 1'b0;
        end else if (w_accept) begin
            r_state      <= HOLD;
            r_last_grant <= w_grant[1];
            r_rsp_id     <= w_grant[1];
            r_rsp_s      <= bus.alu_s;
            r_rsp_z      <= bus.alu_z;
        end else if ((r_state == HOLD) && bus.rsp_ready) begin
            r_state <= IDLE;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_accept) begin
            if (w_grant[0] && (r_cnt0 != {CNT_W{1'b1}})) r_cnt0 <= r_cnt0 + CNT_W'(1);
            if (w_grant[1] && (r_cnt1 != {CNT_W{1'b1}})) r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`else
    logic [31:0] w_unused_cnt_w;
    assign w_unused_cnt_w = 32'(CNT_W);
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed and randomized self-checking bench for alu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_arb_pkg::*;

`ifdef ALU_ARB_STATS_EN
    localparam int TB_CNT_W = 2;
    logic [TB_CNT_W-1:0] gc0;
    logic [TB_CNT_W-1:0] gc1;
`else
    localparam int TB_CNT_W = 16;
`endif

    typedef struct {
        logic        id;
        logic [31:0] s;
        logic        z;
    } rsp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    alu_arbiter_if bus ();

    alu_arbiter #(.CNT_W(TB_CNT_W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (gc0),
        .grant_cnt1 (gc1)
`endif
    );

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        case (op)
            c_ALUC_ADD: return a + b;
            c_ALUC_SUB: return a - b;
            c_ALUC_AND: return a & b;
            c_ALUC_OR:  return a | b;
            c_ALUC_XOR: return a ^ b;
            c_ALUC_LUI: return {b[15:0], 16'h0000};
            c_ALUC_SLL: return b << a[4:0];
            c_ALUC_SRL: return b >> a[4:0];
            c_ALUC_SRA: return 32'($signed(b) >>> a[4:0]);
            default:    return 32'd0;
        endcase
    endfunction

    // Behavioural stand-in for the shared combinational ALU.
    assign bus.alu_s = alu_f(bus.alu_a, bus.alu_b, bus.alu_aluc);
    assign bus.alu_z = (bus.alu_s == 32'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req0_aluc = 4'd0;
        bus.req1_valid = 1'b0; bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_aluc = 4'd0;
        bus.rsp_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_id !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_id: got %b expected 0", bus.rsp_id); end
        n_checks++; if (bus.rsp_s !== 32'd0) begin n_errors++; $display("FAIL reset_rsp_s: got %h expected 0", bus.rsp_s); end
        n_checks++; if (bus.rsp_z !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_z: got %b expected 0", bus.rsp_z); end
        n_checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_errors++; $display("FAIL reset_ready: got %b expected 00", {bus.req1_ready, bus.req0_ready}); end
`ifdef ALU_ARB_STATS_EN
        n_checks++; if ({gc1, gc0} !== '0) begin n_errors++; $display("FAIL reset_counters: got %h/%h expected 0/0", gc0, gc1); end
`endif
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single_add();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd7; bus.req0_aluc = c_ALUC_ADD;
        bus.rsp_ready  = 1'b1;
        #1;
        n_checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_errors++; $display("FAIL add_ready: got %b expected 01", {bus.req1_ready, bus.req0_ready}); end
        n_checks++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin n_errors++; $display("FAIL add_alu_drive: got %h/%h expected 5/7", bus.alu_a, bus.alu_b); end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0) begin n_errors++; $display("FAIL add_rsp_hdr: got v=%b id=%b expected v=1 id=0", bus.rsp_valid, bus.rsp_id); end
        n_checks++; if (bus.rsp_s !== 32'd12 || bus.rsp_z !== 1'b0) begin n_errors++; $display("FAIL add_rsp_data: got s=%0d z=%b expected s=12 z=0", bus.rsp_s, bus.rsp_z); end
        n_checks++; if (bus.alu_a !== 32'd0 || bus.alu_aluc !== 4'd0) begin n_errors++; $display("FAIL idle_alu_drive: got %h/%h expected 0/0", bus.alu_a, bus.alu_aluc); end
        @(negedge clk); #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL add_rsp_drain: got %b expected 0", bus.rsp_valid); end
    endtask

    task automatic test_alternate();
        logic [31:0] exp_s;
        logic        exp_id;
        exp_s  = 32'd0;
        exp_id = 1'b0;
        apply_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req0_valid = (i < 4); bus.req0_a = 32'(i + 1);   bus.req0_b = 32'd10; bus.req0_aluc = c_ALUC_ADD;
            bus.req1_valid = (i < 4); bus.req1_a = 32'(i + 100); bus.req1_b = 32'd10; bus.req1_aluc = c_ALUC_ADD;
            #1;
            if (i > 0) begin
                n_checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_id || bus.rsp_s !== exp_s) begin
                    n_errors++;
                    $display("FAIL alt_rsp[%0d]: got v=%b id=%b s=%0d expected v=1 id=%b s=%0d", i, bus.rsp_valid, bus.rsp_id, bus.rsp_s, exp_id, exp_s);
                end
            end
            if (i < 4) begin
                exp_id = (i % 2 == 1);
                exp_s  = exp_id ? 32'(i + 110) : 32'(i + 11);
                n_checks++;
                if (bus.req0_ready !== !exp_id || bus.req1_ready !== exp_id) begin
                    n_errors++;
                    $display("FAIL alt_grant[%0d]: got %b expected %b", i, {bus.req1_ready, bus.req0_ready}, {exp_id, !exp_id});
                end
            end
        end
        @(negedge clk); #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL alt_drain: got %b expected 0", bus.rsp_valid); end
    endtask

    task automatic test_hold_stall();
        @(negedge clk);
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd9; bus.req1_b = 32'd9; bus.req1_aluc = c_ALUC_SUB;
        #1;
        n_checks++; if (bus.req1_ready !== 1'b1) begin n_errors++; $display("FAIL stall_accept: got %b expected 1", bus.req1_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.req1_a     = 32'h55 + 32'(k);
            bus.req0_valid = 1'b1; bus.req0_a = 32'd3; bus.req0_b = 32'd4; bus.req0_aluc = c_ALUC_ADD;
            #1;
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_s !== 32'd0 || bus.rsp_z !== 1'b1) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: got v=%b id=%b s=%h z=%b expected v=1 id=1 s=0 z=1", k, bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.rsp_z);
            end
            n_checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_errors++; $display("FAIL stall_ready[%0d]: got %b expected 00", k, {bus.req1_ready, bus.req0_ready}); end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.rsp_ready  = 1'b1;
        bus.req1_valid = 1'b0;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1 || bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_ready: got r0=%b v=%b expected r0=1 v=1", bus.req0_ready, bus.rsp_valid); end
        @(negedge clk);
        bus.req0_a = 32'd20; bus.req0_b = 32'd22;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_s !== 32'd7) begin n_errors++; $display("FAIL b2b_rsp1: got v=%b id=%b s=%0d expected v=1 id=0 s=7", bus.rsp_valid, bus.rsp_id, bus.rsp_s); end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_s !== 32'd42) begin n_errors++; $display("FAIL b2b_rsp2: got v=%b s=%0d expected v=1 s=42", bus.rsp_valid, bus.rsp_s); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd1; bus.req0_aluc = c_ALUC_ADD;
        @(negedge clk); #1;
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL areset_pre: got %b expected 1", bus.rsp_valid); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL areset_drop: got %b expected 0", bus.rsp_valid); end
        n_checks++; if (bus.req0_ready !== 1'b0) begin n_errors++; $display("FAIL areset_ready: got %b expected 0", bus.req0_ready); end
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd2; bus.req1_b = 32'd2; bus.req1_aluc = c_ALUC_ADD;
        #1;
        n_checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_errors++; $display("FAIL areset_tie: got %b expected 01", {bus.req1_ready, bus.req0_ready}); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_s !== 32'd2) begin n_errors++; $display("FAIL areset_rsp: got id=%b s=%0d expected id=0 s=2", bus.rsp_id, bus.rsp_s); end
    endtask

    task automatic test_random();
        logic [3:0]        ops [9];
        rsp_t              q [$];
        rsp_t              e;
        logic              m_last;
        logic              v0, v1, rr, win, acc;
        logic [31:0]       ea, eb;
        logic [3:0]        eop;
        int unsigned       cnt0, cnt1;
        ops = '{c_ALUC_ADD, c_ALUC_SUB, c_ALUC_AND, c_ALUC_OR, c_ALUC_XOR,
                c_ALUC_LUI, c_ALUC_SLL, c_ALUC_SRL, c_ALUC_SRA};
        apply_reset();
        m_last = 1'b1;
        cnt0   = 0;
        cnt1   = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            v0 = ($urandom_range(0, 2) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            rr = ($urandom_range(0, 3) != 0);
            bus.req0_valid = v0; bus.req0_a = $urandom(); bus.req0_aluc = ops[$urandom_range(0, 8)];
            bus.req0_b = ($urandom_range(0, 3) == 0) ? bus.req0_a : $urandom();
            bus.req1_valid = v1; bus.req1_a = $urandom(); bus.req1_aluc = ops[$urandom_range(0, 8)];
            bus.req1_b = ($urandom_range(0, 3) == 0) ? bus.req1_a : $urandom();
            bus.rsp_ready = rr;
            #1;
            win = (v0 && v1) ? ~m_last : v1;
            acc = (v0 || v1) && (q.size() == 0 || rr);
            ea  = !(v0 || v1) ? 32'd0 : (win ? bus.req1_a : bus.req0_a);
            eb  = !(v0 || v1) ? 32'd0 : (win ? bus.req1_b : bus.req0_b);
            eop = !(v0 || v1) ? 4'd0  : (win ? bus.req1_aluc : bus.req0_aluc);
            n_checks++;
            if (bus.req0_ready !== (acc && !win) || bus.req1_ready !== (acc && win)) begin
                n_errors++;
                $display("FAIL rnd_ready[%0d]: got %b expected %b", cyc, {bus.req1_ready, bus.req0_ready}, {acc && win, acc && !win});
            end
            n_checks++;
            if (bus.alu_a !== ea || bus.alu_b !== eb || bus.alu_aluc !== eop) begin
                n_errors++;
                $display("FAIL rnd_alu[%0d]: got %h/%h/%h expected %h/%h/%h", cyc, bus.alu_a, bus.alu_b, bus.alu_aluc, ea, eb, eop);
            end
            n_checks++;
            if (bus.rsp_valid !== (q.size() != 0)) begin
                n_errors++;
                $display("FAIL rnd_rsp_valid[%0d]: got %b expected %b", cyc, bus.rsp_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_checks++;
                if (bus.rsp_id !== q[0].id || bus.rsp_s !== q[0].s || bus.rsp_z !== q[0].z) begin
                    n_errors++;
                    $display("FAIL rnd_rsp[%0d]: got id=%b s=%h z=%b expected id=%b s=%h z=%b", cyc, bus.rsp_id, bus.rsp_s, bus.rsp_z, q[0].id, q[0].s, q[0].z);
                end
            end
`ifdef ALU_ARB_STATS_EN
            n_checks++;
            if (32'(gc0) != cnt0 || 32'(gc1) != cnt1) begin
                n_errors++;
                $display("FAIL rnd_counters[%0d]: got %0d/%0d expected %0d/%0d", cyc, gc0, gc1, cnt0, cnt1);
            end
`endif
            if (q.size() != 0 && rr) void'(q.pop_front());
            if (acc) begin
                e.id = win;
                e.s  = alu_f(ea, eb, eop);
                e.z  = (e.s == 32'd0);
                q.push_back(e);
                m_last = win;
                if (!win && cnt0 < (1 << TB_CNT_W) - 1) cnt0++;
                if (win && cnt1 < (1 << TB_CNT_W) - 1) cnt1++;
            end
        end
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        apply_reset();
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.req0_valid = 1'b1; bus.req0_a = 32'(k); bus.req0_b = 32'd1; bus.req0_aluc = c_ALUC_ADD;
            #1;
            if (k == 2) begin
                n_checks++; if (gc0 !== 2'd2) begin n_errors++; $display("FAIL stats_mid: got %0d expected 2", gc0); end
            end
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        n_checks++; if (gc0 !== 2'd3 || gc1 !== 2'd0) begin n_errors++; $display("FAIL stats_sat: got %0d/%0d expected 3/0", gc0, gc1); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_single_add();
        test_alternate();
        test_hold_stall();
        test_back_to_back();
        test_async_reset();
        test_random();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of per-requester grant counters.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  requester has an operation pending.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  operation accepted this cycle.
REQ-007 SHALL have ports req0_a/req1_a, req0_b/req1_b  input  32  operands.
REQ-008 SHALL have ports req0_aluc/req1_aluc  input  4  ALU opcode.
REQ-009 SHALL have ports alu_a, alu_b  output  32, alu_aluc  output  4  drive to the shared combinational ALU.
REQ-010 SHALL have ports alu_s  input  32, alu_z  input  1  ALU result and zero flag.
REQ-011 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (winning requester), rsp_s  output  32, rsp_z  output  1.
REQ-012 SHALL have ports grant_cnt0/grant_cnt1  output  CNT_W  (only with ALU_ARB_STATS_EN).

Function
REQ-013 SHALL share one combinational ALU between two requesters, one accepted operation per cycle maximum.
REQ-014 SHALL use states IDLE (no response held) and HOLD (rsp_valid=1, awaiting rsp_ready).
REQ-015 SHALL compute grant from req*_valid and last_grant only (never from rsp_ready) to avoid combinational loops.
REQ-016 Grant: one valid -> that requester; both valid -> requester != last_grant; none -> no grant.
REQ-017 SHALL assert reqN_ready = grantN & (state==IDLE | rsp_ready).
REQ-018 SHALL drive alu_a/alu_b/alu_aluc from the granted requester; with no grant, drive 0/0/4'b0000.
REQ-019 On accept (valid&ready), SHALL register alu_s, alu_z, grant id into rsp_s, rsp_z, rsp_id at the same edge; response appears 1 cycle after accept.
REQ-020 Transitions: IDLE+accept -> HOLD; HOLD+rsp_ready+accept -> HOLD with new data; HOLD+rsp_ready, no accept -> IDLE; HOLD, no rsp_ready -> HOLD, rsp_* stable.
REQ-021 SHALL update last_grant only on accept; unaccepted grants do not rotate priority.
REQ-022 SHALL hold rsp_s/rsp_z/rsp_id stable whenever rsp_valid=1 and rsp_ready=0.
REQ-023 Requester operands may change while not accepted; only accept-cycle values are used.

Reset
REQ-024 On reset SHALL force state=IDLE, rsp_valid=0, rsp_id=0, rsp_s=0, rsp_z=0, last_grant=1 (requester 0 wins first tie), grant counters=0.
REQ-025 Reset mid-HOLD SHALL drop the pending response without delivery; req*_ready SHALL be 0 while reset asserted.

Configuration
REQ-026 Macro ALU_ARB_STATS_EN defined: grant_cnt0/grant_cnt1 increment on each accept of that requester, saturating at 2^CNT_W-1.
REQ-027 Macro ALU_ARB_STATS_EN undefined: counters and grant_cnt* ports absent; all other behaviour identical.

Structure
REQ-028 Shared package alu_arb_pkg SHALL hold ALUC opcode constants (ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111) and state encoding IDLE/HOLD.
REQ-029 Grant logic SHALL be one sub-module alu_rr_arb (2-way round-robin, inputs valids/last_grant, outputs one-hot grant).

Verification
REQ-030 Reset, req0 ADD a=5 b=7, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_s=12, rsp_z=0.
REQ-031 Both valid continuously, rsp_ready=1, 4 cycles -> grants 0,1,0,1; rsp_id sequence 0,1,0,1; one response per cycle.
REQ-032 req1 SUB a=9 b=9, rsp_ready=0 for 3 cycles -> rsp_valid=1, rsp_s=0, rsp_z=1 held stable; req*_ready=0 until rsp_ready=1.
REQ-033 HOLD with rsp_ready=1 and req0 valid -> old response consumed and new accepted in same cycle, no bubble.
REQ-034 Reset asserted asynchronously during HOLD -> rsp_valid falls immediately without clock; after release req0 wins first tie.
REQ-035 With ALU_ARB_STATS_EN, CNT_W=2, 5 req0 accepts -> grant_cnt0=3 (saturated), grant_cnt1=0.
